// File: rtl/fetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package   : fetch_pkg                                            |
// | Purpose   : Shared types and constants for the instruction-fetch |
// |             sequencer: FSM state encoding, MIPS opcodes used for |
// |             control flow, default reset PC, branch offset helper.|
// | Revision  : 1.0 - initial release                                |
// +------------------------------------------------------------------+
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_DBG   = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [5:0]  OP_J   = 6'h02;
  localparam logic [5:0]  OP_BEQ = 6'h04;
  localparam logic [5:0]  OP_BNE = 6'h05;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Branch displacement in bytes: sign-extended word offset times four.
  function automatic logic [31:0] br_byte_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : next_pc_calc                                         |
// | Purpose   : Combinational next-PC selection for sequential,      |
// |             jump (j) and conditional branch (beq/bne) flow, plus |
// |             an out-of-ROM-range flag on the resulting PC.        |
// | Revision  : 1.0 - initial release                                |
// +------------------------------------------------------------------+
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int ROM_DEPTH = 21
) (
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rom_inst,
  input  logic        i_br_cond,
  output logic [31:0] o_next_pc,
  output logic        o_out_of_range
);

  localparam logic [31:0] c_ROM_DEPTH = ROM_DEPTH[31:0];

  logic [31:0] w_pc4;
  logic [5:0]  w_opcode;

  assign w_pc4    = i_pc + 32'd4;
  assign w_opcode = i_rom_inst[31:26];

  // Select the flow target; all sums wrap modulo 2^32.
  always_comb begin
    o_next_pc = w_pc4;
    if (w_opcode == OP_J) begin
      o_next_pc = {w_pc4[31:28], i_rom_inst[25:0], 2'b00};
    end else if (((w_opcode == OP_BEQ) || (w_opcode == OP_BNE)) && i_br_cond) begin
      o_next_pc = w_pc4 + br_byte_offset(i_rom_inst[15:0]);
    end
  end

  // Word index at or beyond the implemented ROM depth is a fault.
  assign o_out_of_range = ({2'b00, o_next_pc[31:2]} >= c_ROM_DEPTH);

endmodule
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : inst_fetch_ctrl                                      |
// | Purpose   : Instruction-fetch sequencer. Owns the PC, drives the |
// |             ROM address, gates free-run / single-step execution  |
// |             and time-shares the ROM port with a debug reader.    |
// | Config    : FETCH_DBG_PORT_EN - define to enable the debug read  |
// |             port; otherwise dbg_ack/dbg_data are held at zero.   |
// | Revision  : 1.0 - initial release                                |
// +------------------------------------------------------------------+
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          ROM_AW    = 5,
  parameter int          ROM_DEPTH = 21,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mode_run,
  input  logic              i_step_pulse,
  input  logic              i_br_cond,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [31:0]       i_rom_inst,
  output logic [31:0]       o_inst,
  output logic              o_inst_valid,
  output logic [31:0]       o_pc,
  input  logic              i_dbg_req,
  input  logic [ROM_AW-1:0] i_dbg_addr,
  output logic              o_dbg_ack,
  output logic [31:0]       o_dbg_data,
  output logic              o_fault
);

`ifdef FETCH_DBG_PORT_EN
  localparam logic c_DBG_EN = 1'b1;
`else
  localparam logic c_DBG_EN = 1'b0;
`endif

  fetch_state_e      r_state;
  logic [31:0]       r_pc;
  logic              r_step_pending;
  logic              r_last_dbg;      // last non-IDLE state was DBG
  logic              r_dbg_ack;
  logic [31:0]       r_dbg_data;
  logic [ROM_AW-1:0] r_dbg_addr;
  logic              r_fault;

  logic [31:0]       w_next_pc;
  logic              w_out_of_range;
  logic              w_dbg_take_idle;
  logic              w_dbg_take_exec;

  next_pc_calc #(
    .ROM_DEPTH (ROM_DEPTH)
  ) u_next_pc_calc (
    .i_pc           (r_pc),
    .i_rom_inst     (i_rom_inst),
    .i_br_cond      (i_br_cond),
    .o_next_pc      (w_next_pc),
    .o_out_of_range (w_out_of_range)
  );

  // In IDLE the debugger wins, except right after its own access when a
  // fetch is already wanted; the ack cycle never starts a new access.
  assign w_dbg_take_idle = c_DBG_EN && i_dbg_req && !r_dbg_ack &&
                           !(r_last_dbg && (i_mode_run || r_step_pending));
  assign w_dbg_take_exec = c_DBG_EN && i_dbg_req;

  // Sequencer: state, PC, step bookkeeping and debug capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_pc           <= RESET_PC;
      r_step_pending <= 1'b0;
      r_last_dbg     <= 1'b0;
      r_dbg_ack      <= 1'b0;
      r_dbg_data     <= '0;
      r_dbg_addr     <= '0;
      r_fault        <= 1'b0;
    end else begin
      r_dbg_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_dbg_take_idle) begin
            r_state    <= ST_DBG;
            r_dbg_addr <= i_dbg_addr;
            if (i_step_pulse) r_step_pending <= 1'b1;
          end else if (i_mode_run || i_step_pulse || r_step_pending) begin
            r_state        <= ST_EXEC;
            r_step_pending <= 1'b0;
            r_last_dbg     <= 1'b0;
          end
        end
        ST_EXEC: begin
          r_pc <= w_next_pc;
          if (w_out_of_range) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
          end else if (w_dbg_take_exec) begin
            r_state    <= ST_DBG;
            r_dbg_addr <= i_dbg_addr;
          end else if (!i_mode_run) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DBG: begin
          r_dbg_data <= i_rom_inst;
          r_dbg_ack  <= 1'b1;
          r_last_dbg <= 1'b1;
          r_state    <= ST_IDLE;
          if (i_step_pulse) r_step_pending <= 1'b1;
        end
        ST_FAULT: begin
          r_state <= ST_FAULT;
        end
      endcase
    end
  end

  assign o_rom_addr   = (r_state == ST_DBG) ? r_dbg_addr : r_pc[ROM_AW+1:2];
  assign o_inst_valid = (r_state == ST_EXEC);
  assign o_inst       = o_inst_valid ? i_rom_inst : 32'h0;
  assign o_pc         = r_pc;
  assign o_fault      = r_fault;
  assign o_dbg_ack    = c_DBG_EN & r_dbg_ack;
  assign o_dbg_data   = c_DBG_EN ? r_dbg_data : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : tb_inst_fetch_ctrl                                   |
// | Purpose   : Self-checking bench for inst_fetch_ctrl: next-PC     |
// |             vector table plus run, step, fault and debug-port    |
// |             sequences against a small behavioural ROM.           |
// | Config    : FETCH_DBG_PORT_EN selects the debug expectations.    |
// | Revision  : 1.0 - initial release                                |
// +------------------------------------------------------------------+
module tb_inst_fetch_ctrl;

  localparam int c_AW    = 5;
  localparam int c_DEPTH = 21;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            mode_run = 1'b0;
  logic            step_pulse = 1'b0;
  logic            br_cond = 1'b0;
  logic [c_AW-1:0] rom_addr;
  logic [31:0]     rom_inst;
  logic [31:0]     inst;
  logic            inst_valid;
  logic [31:0]     pc;
  logic            dbg_req = 1'b0;
  logic [c_AW-1:0] dbg_addr = '0;
  logic            dbg_ack;
  logic [31:0]     dbg_data;
  logic            fault;

  logic [31:0]     rom [0:31];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Behavioural ROM: unimplemented words read as zero.
  always_comb begin
    rom_inst = 32'h0;
    if (rom_addr < c_DEPTH[c_AW-1:0]) rom_inst = rom[rom_addr];
  end

  inst_fetch_ctrl #(
    .ROM_AW    (c_AW),
    .ROM_DEPTH (c_DEPTH),
    .RESET_PC  (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_mode_run   (mode_run),
    .i_step_pulse (step_pulse),
    .i_br_cond    (br_cond),
    .o_rom_addr   (rom_addr),
    .i_rom_inst   (rom_inst),
    .o_inst       (inst),
    .o_inst_valid (inst_valid),
    .o_pc         (pc),
    .i_dbg_req    (dbg_req),
    .i_dbg_addr   (dbg_addr),
    .o_dbg_ack    (dbg_ack),
    .o_dbg_data   (dbg_data),
    .o_fault      (fault)
  );

  // Stand-alone next-PC unit for the vector table.
  logic [31:0] tv_pc, tv_inst, tv_next;
  logic        tv_br, tv_oor;

  next_pc_calc #(.ROM_DEPTH(c_DEPTH)) u_npc (
    .i_pc           (tv_pc),
    .i_rom_inst     (tv_inst),
    .i_br_cond      (tv_br),
    .o_next_pc      (tv_next),
    .o_out_of_range (tv_oor)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        br;
    logic [31:0] exp_pc;
    logic        exp_oor;
  } npc_vec_t;

  npc_vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin : main
    int cnt;
    int acks;
    int exec_since;
    logic got;

    for (int i = 0; i < 32; i++) rom[i] = 32'h0;
    rom[0]  = 32'h24020001;
    rom[1]  = 32'h24030001;
    rom[2]  = 32'h24040001;
    rom[6]  = 32'h10A00006;
    rom[11] = 32'h08000010;
    rom[19] = 32'h08000003;

    vecs[0]  = '{32'h0000002C, 32'h08000010, 1'b0, 32'h00000040, 1'b0};
    vecs[1]  = '{32'h0000004C, 32'h08000003, 1'b0, 32'h0000000C, 1'b0};
    vecs[2]  = '{32'h00000018, 32'h10A00006, 1'b1, 32'h00000034, 1'b0};
    vecs[3]  = '{32'h00000018, 32'h10A00006, 1'b0, 32'h0000001C, 1'b0};
    vecs[4]  = '{32'h00000018, 32'h14A0FFFE, 1'b1, 32'h00000014, 1'b0};
    vecs[5]  = '{32'h0000001C, 32'h10A0FFF8, 1'b1, 32'h00000000, 1'b0};
    vecs[6]  = '{32'h00000000, 32'h24020001, 1'b1, 32'h00000004, 1'b0};
    vecs[7]  = '{32'h0000004C, 32'h00000000, 1'b0, 32'h00000050, 1'b0};
    vecs[8]  = '{32'h00000050, 32'h00000000, 1'b0, 32'h00000054, 1'b1};
    vecs[9]  = '{32'hFFFFFFFC, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vecs[10] = '{32'hF000002C, 32'h08000010, 1'b0, 32'hF0000040, 1'b1};
    vecs[11] = '{32'h00000010, 32'h0C000005, 1'b1, 32'h00000014, 1'b0};

    // Next-PC vector table.
    for (int i = 0; i < 12; i++) begin
      tv_pc   = vecs[i].pc;
      tv_inst = vecs[i].inst;
      tv_br   = vecs[i].br;
      #1;
      chk($sformatf("npc_vec%0d_pc", i), tv_next, vecs[i].exp_pc);
      chk($sformatf("npc_vec%0d_oor", i), {31'b0, tv_oor}, {31'b0, vecs[i].exp_oor});
    end

    // Reset state, then free-run from word 0.
    mode_run = 1'b1;
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_dbg_ack", {31'b0, dbg_ack}, 32'h0);
    chk("rst_dbg_data", dbg_data, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    for (int k = 0; k <= 16; k++) begin
      tick();
      if (k == 0) chk("run_inst0", inst, 32'h24020001);
      if (k <= 2) begin
        chk($sformatf("run_pc%0d", k), pc, 32'(k * 4));
        chk($sformatf("run_valid%0d", k), {31'b0, inst_valid}, 32'h1);
      end
      if (k == 12) chk("run_jump_fwd_pc", pc, 32'h40);
      if (k == 16) chk("run_jump_back_pc", pc, 32'h0C);
    end
    // Dropping run mode lets the current instruction finish, then idles.
    mode_run = 1'b0;
    tick();
    chk("runstop_pc", pc, 32'h10);
    chk("runstop_valid", {31'b0, inst_valid}, 32'h0);
    tick();
    chk("runstop_hold_pc", pc, 32'h10);

    // Single-step: pulses at cycles 5 and 9.
    do_reset();
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      step_pulse = (c == 5) || (c == 9);
      tick();
      if (inst_valid) cnt++;
    end
    step_pulse = 1'b0;
    chk("step_count", 32'(cnt), 32'd2);
    chk("step_pc", pc, 32'h8);
    // Pulse arriving while executing is ignored.
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step_pulse = (c < 2);
      tick();
      if (inst_valid) cnt++;
    end
    step_pulse = 1'b0;
    chk("step_dbl_count", 32'(cnt), 32'd1);
    chk("step_dbl_pc", pc, 32'hC);

    // Fault: jump to word 21 (0x54).
    rom[19] = 32'h08000015;
    mode_run = 1'b1;
    do_reset();
    for (int k = 0; k <= 15; k++) tick();
    chk("pre_fault_pc", pc, 32'h4C);
    chk("pre_fault_flag", {31'b0, fault}, 32'h0);
    tick();
    chk("fault_pc", pc, 32'h54);
    chk("fault_flag", {31'b0, fault}, 32'h1);
    chk("fault_valid", {31'b0, inst_valid}, 32'h0);
    chk("fault_inst", inst, 32'h0);
    tick(); tick(); tick();
    chk("fault_sticky", {31'b0, fault}, 32'h1);
    chk("fault_pc_hold", pc, 32'h54);
    rst = 1'b1;
    tick();
    chk("fault_rst_pc", pc, 32'h0);
    chk("fault_rst_flag", {31'b0, fault}, 32'h0);
    rst = 1'b0;
    rom[19] = 32'h08000003;

`ifdef FETCH_DBG_PORT_EN
    // Debug read in run mode.
    mode_run = 1'b1;
    do_reset();
    tick(); tick();
    dbg_req  = 1'b1;
    dbg_addr = 5'd19;
    got = 1'b0;
    cnt = 0;
    while (!got && cnt < 3) begin
      tick();
      cnt++;
      got = dbg_ack;
    end
    dbg_req = 1'b0;
    chk("dbg_ack_seen", {31'b0, got}, 32'h1);
    chk("dbg_data_w19", dbg_data, 32'h08000003);

    // Continuous requests still let instructions through.
    dbg_req  = 1'b1;
    dbg_addr = 5'd0;
    acks = 0;
    exec_since = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (dbg_ack) begin
        if (acks > 0) chk("dbg_fair_exec", {31'b0, exec_since >= 1}, 32'h1);
        exec_since = 0;
        acks++;
      end
      if (inst_valid) exec_since++;
    end
    dbg_req = 1'b0;
    chk("dbg_ack_count", {31'b0, acks >= 6}, 32'h1);

    // Step pulse coincident with a debug request in IDLE.
    mode_run = 1'b0;
    do_reset();
    dbg_req    = 1'b1;
    dbg_addr   = 5'd1;
    step_pulse = 1'b1;
    tick();
    step_pulse = 1'b0;
    got = 1'b0;
    cnt = 0;
    while (!got && cnt < 4) begin
      tick();
      cnt++;
      got = dbg_ack;
    end
    dbg_req = 1'b0;
    chk("dbgstep_ack_seen", {31'b0, got}, 32'h1);
    chk("dbgstep_data", dbg_data, 32'h24030001);
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (inst_valid) cnt++;
    end
    chk("dbgstep_exec_count", 32'(cnt), 32'd1);
    chk("dbgstep_pc", pc, 32'h4);

    // Out-of-range debug address reads zero.
    dbg_req  = 1'b1;
    dbg_addr = 5'd25;
    got = 1'b0;
    cnt = 0;
    while (!got && cnt < 4) begin
      tick();
      cnt++;
      got = dbg_ack;
    end
    dbg_req = 1'b0;
    chk("dbg_oor_ack_seen", {31'b0, got}, 32'h1);
    chk("dbg_oor_data", dbg_data, 32'h0);
`else
    // Debug port disabled: requests are ignored, execution continues.
    mode_run = 1'b1;
    do_reset();
    dbg_req  = 1'b1;
    dbg_addr = 5'd19;
    acks = 0;
    cnt  = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (dbg_ack) acks++;
      if (inst_valid) cnt++;
    end
    dbg_req = 1'b0;
    chk("nodbg_ack_count", 32'(acks), 32'd0);
    chk("nodbg_exec_count", 32'(cnt), 32'd8);
    chk("nodbg_data", dbg_data, 32'h0);
    chk("nodbg_pc", pc, 32'h1C);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
